// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared state encoding, frame constants and parity helper for the PS/2 host transmitter
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam int FRAME_BITS = 10;
    localparam int ACK_EDGE   = 11;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command handshake and status bundle between a requester and ps2_host_tx
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  busy,
        input  done,
        input  ack_err,
        input  timeout
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output busy,
        output done,
        output ack_err,
        output timeout
    );

endinterface

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-FF synchroniser, stability filter and falling-edge pulse for one PS/2 line
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic ck,
    input  logic reset,
    input  logic line,
    output logic level,
    output logic fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;

    // The bus idles high, so the synchroniser and filtered level reset to 1.
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            level  <= 1'b1;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line};
            fall   <= 1'b0;
            if (sync_q[1] == level) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                cnt_q <= '0;
                level <= sync_q[1];
                fall  <= ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter with inhibit, request, shift, ACK and timeout
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int REQ_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic          ck,
    input  logic          reset,
    ps2_host_tx_if.slave  tif,
    input  logic          scl,
    input  logic          sda,
    output logic          scl_oe,
    output logic          sda_oe
);

    import ps2_pkg::*;

    localparam int PMAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_e            state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [3:0]            bit_q, bit_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic                  ack_err_q, ack_err_d;
    logic                  scl_oe_q, scl_oe_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  done_q, done_d;
    logic                  timeout_q, timeout_d;
    logic [1:0]            sda_sync_q;
    logic                  scl_level, scl_fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .ck    (ck),
        .reset (reset),
        .line  (scl),
        .level (scl_level),
        .fall  (scl_fall)
    );

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            tmo_q      <= '0;
            bit_q      <= '0;
            frame_q    <= '0;
            ack_err_q  <= 1'b0;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            sda_sync_q <= 2'b11;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            tmo_q      <= tmo_d;
            bit_q      <= bit_d;
            frame_q    <= frame_d;
            ack_err_q  <= ack_err_d;
            scl_oe_q   <= scl_oe_d;
            sda_oe_q   <= sda_oe_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            sda_sync_q <= {sda_sync_q[0], sda};
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        tmo_d     = tmo_q;
        bit_d     = bit_q;
        frame_d   = frame_q;
        ack_err_d = ack_err_q;
        scl_oe_d  = scl_oe_q;
        sda_oe_d  = sda_oe_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (tif.tx_valid) begin
                    frame_d   = {1'b1, odd_parity(tif.tx_data), tif.tx_data};
                    ack_err_d = 1'b0;
                    phase_d   = '0;
                    scl_oe_d  = 1'b1;
                    sda_oe_d  = 1'b0;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (phase_q == PW'(INHIBIT_CYCLES - 1)) begin
                    phase_d  = '0;
                    sda_oe_d = 1'b1;
                    state_d  = REQ;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            REQ: begin
                if (phase_q == PW'(REQ_CYCLES - 1)) begin
                    scl_oe_d = 1'b0;
                    bit_d    = '0;
                    tmo_d    = '0;
                    state_d  = SHIFT;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            SHIFT: begin
                // The start bit is already on sda; each device fall presents the next frame bit.
                if (scl_fall) begin
                    sda_oe_d = ~frame_q[0];
                    frame_d  = frame_q >> 1;
                    bit_d    = bit_q + 1'b1;
                    if (bit_q == 4'(FRAME_BITS - 1)) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                if (scl_fall) begin
                    ack_err_d = sda_sync_q[1];
                    state_d   = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (scl_level && sda_sync_q[1]) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A device clock edge always restarts the watchdog, even on its terminal cycle.
        if (state_q == SHIFT || state_q == ACK || state_q == WAIT_IDLE) begin
            if (scl_fall) begin
                tmo_d = '0;
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                scl_oe_d  = 1'b0;
                sda_oe_d  = 1'b0;
                done_d    = 1'b0;
                timeout_d = 1'b1;
                state_d   = IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    assign scl_oe      = scl_oe_q;
    assign sda_oe      = sda_oe_q;
    assign tif.tx_ready = (state_q == IDLE);
    assign tif.busy     = (state_q != IDLE);
    assign tif.done     = done_q;
    assign tif.ack_err  = ack_err_q;
    assign tif.timeout  = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - randomized self-checking bench for ps2_host_tx with a behavioural PS/2 device
module tb_ps2_host_tx;

    localparam int INH      = 60;
    localparam int REQ      = 16;
    localparam int TMO      = 2000;
    localparam int FL       = 8;
    localparam int HALF     = 40;
    localparam int FALL_LAT = 3 + FL;

    logic ck = 1'b0;
    logic reset = 1'b0;
    logic dev_scl = 1'b1;
    logic dev_sda = 1'b1;
    logic scl, sda, scl_oe, sda_oe;

    ps2_host_tx_if tif ();

    assign scl = dev_scl & ~scl_oe;
    assign sda = dev_sda & ~sda_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .REQ_CYCLES     (REQ),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FL)
    ) dut (
        .ck     (ck),
        .reset  (reset),
        .tif    (tif),
        .scl    (scl),
        .sda    (sda),
        .scl_oe (scl_oe),
        .sda_oe (sda_oe)
    );

    always #5 ck = ~ck;

    int cyc = 0;
    int done_cnt = 0;
    int tmo_cnt = 0;
    int tmo_at = 0;
    logic ack_at_done = 1'b0;
    int n_cmp = 0;
    int n_err = 0;

    always @(posedge ck) cyc = cyc + 1;

    always @(negedge ck) begin
        if (tif.done) begin
            done_cnt = done_cnt + 1;
            ack_at_done = tif.ack_err;
        end
        if (tif.timeout) begin
            tmo_cnt = tmo_cnt + 1;
            tmo_at = cyc;
        end
    end

    logic [10:0] seen;
    int          lat1;
    logic        start_bit;
    int          last_fall;
    int          oe_cnt;
    int          req_cnt;
    logic        acc_ready;

    function automatic logic [9:0] model_frame(input logic [7:0] d);
        int ones;
        logic [9:0] f;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = d[i];
            ones += int'(d[i]);
        end
        f[8] = (ones % 2 == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] d, input bit poke);
        @(negedge ck);
        tif.tx_data = d;
        tif.tx_valid = 1'b1;
        acc_ready = tif.tx_ready;
        @(negedge ck);
        tif.tx_valid = poke;
        tif.tx_data = poke ? ~d : d;
        oe_cnt = 0;
        req_cnt = 0;
        while (scl_oe && oe_cnt < 10000) begin
            oe_cnt++;
            if (sda_oe) req_cnt++;
            if (oe_cnt == 5) tif.tx_valid = 1'b0;
            @(negedge ck);
        end
    endtask

    task automatic run_device(input int nclk, input bit nack, input bit glitch);
        int w;
        int fall_cyc;
        logic oe_prev;
        int lat;
        w = 0;
        seen = '1;
        lat1 = -1;
        while (!(tif.busy && !scl_oe) && w < 2000) begin
            @(negedge ck);
            w++;
        end
        if (w >= 2000) begin
            n_cmp++;
            n_err++;
            $display("FAIL release_wait: scl never released within %0d cycles", w);
            return;
        end
        start_bit = sda;
        repeat (HALF) @(negedge ck);
        for (int k = 1; k <= nclk; k++) begin
            if (k == 11) dev_sda = nack ? 1'b1 : 1'b0;
            dev_scl = 1'b0;
            fall_cyc = cyc;
            last_fall = cyc;
            oe_prev = sda_oe;
            lat = -1;
            for (int i = 0; i < HALF; i++) begin
                @(negedge ck);
                if (lat < 0 && sda_oe !== oe_prev) lat = cyc - fall_cyc;
            end
            if (k == 1) lat1 = lat;
            seen[k-1] = sda;
            dev_scl = 1'b1;
            if (glitch && k <= 10) begin
                repeat (HALF / 2) @(negedge ck);
                dev_scl = 1'b0;
                repeat (3) @(negedge ck);
                dev_scl = 1'b1;
                repeat (HALF - HALF / 2 - 3) @(negedge ck);
            end else begin
                repeat (HALF) @(negedge ck);
            end
            if (k == 11) dev_sda = 1'b1;
        end
    endtask

    task automatic wait_done(input int d0);
        int w;
        w = 0;
        while (done_cnt == d0 && w < 300) begin
            @(negedge ck);
            w++;
        end
    endtask

    task automatic test_reset;
        tif.tx_valid = 1'b0;
        tif.tx_data = 8'h00;
        reset = 1'b0;
        repeat (3) @(negedge ck);
        n_cmp++; if (tif.tx_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", tif.tx_ready); end
        n_cmp++; if (tif.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", tif.busy); end
        n_cmp++; if ({scl_oe, sda_oe} !== 2'b00) begin n_err++; $display("FAIL reset_oe: got %b want 00", {scl_oe, sda_oe}); end
        n_cmp++; if ({tif.done, tif.ack_err, tif.timeout} !== 3'b000) begin n_err++; $display("FAIL reset_status: got %b want 000", {tif.done, tif.ack_err, tif.timeout}); end
        reset = 1'b1;
        repeat (20) @(negedge ck);
    endtask

    task automatic test_ed;
        int d0;
        logic [9:0] exp_f;
        d0 = done_cnt;
        exp_f = model_frame(8'hED);
        send_byte(8'hED, 1'b0);
        run_device(11, 1'b0, 1'b0);
        wait_done(d0);
        n_cmp++; if (acc_ready !== 1'b1) begin n_err++; $display("FAIL ed_ready_at_accept: got %b want 1", acc_ready); end
        n_cmp++; if (start_bit !== 1'b0) begin n_err++; $display("FAIL ed_start_bit: got %b want 0", start_bit); end
        n_cmp++; if (seen[9:0] !== exp_f) begin n_err++; $display("FAIL ed_frame: got %b want %b", seen[9:0], exp_f); end
        n_cmp++; if (lat1 !== FALL_LAT) begin n_err++; $display("FAIL ed_fall_latency: got %0d want %0d", lat1, FALL_LAT); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL ed_done_count: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (ack_at_done !== 1'b0) begin n_err++; $display("FAIL ed_ack_err: got %b want 0", ack_at_done); end
        @(negedge ck);
        n_cmp++; if (tif.tx_ready !== 1'b1) begin n_err++; $display("FAIL ed_ready_after: got %b want 1", tif.tx_ready); end
    endtask

    task automatic test_f4_inhibit;
        int d0;
        logic [9:0] exp_f;
        d0 = done_cnt;
        exp_f = model_frame(8'hF4);
        send_byte(8'hF4, 1'b1);
        n_cmp++; if (oe_cnt !== INH + REQ) begin n_err++; $display("FAIL f4_scl_low_time: got %0d want %0d", oe_cnt, INH + REQ); end
        n_cmp++; if (req_cnt !== REQ) begin n_err++; $display("FAIL f4_req_time: got %0d want %0d", req_cnt, REQ); end
        run_device(11, 1'b0, 1'b0);
        wait_done(d0);
        n_cmp++; if (seen[9:0] !== exp_f) begin n_err++; $display("FAIL f4_frame: got %b want %b", seen[9:0], exp_f); end
        n_cmp++; if (seen[8] !== 1'b0) begin n_err++; $display("FAIL f4_parity: got %b want 0", seen[8]); end
        n_cmp++; if (done_cnt - d0 !== 1 || ack_at_done !== 1'b0) begin n_err++; $display("FAIL f4_done: got %0d/%b want 1/0", done_cnt - d0, ack_at_done); end
    endtask

    task automatic test_nack;
        int d0;
        d0 = done_cnt;
        send_byte(8'h00, 1'b0);
        run_device(11, 1'b1, 1'b0);
        wait_done(d0);
        n_cmp++; if (seen[8] !== 1'b1) begin n_err++; $display("FAIL nack_parity: got %b want 1", seen[8]); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL nack_done_count: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (ack_at_done !== 1'b1) begin n_err++; $display("FAIL nack_ack_err: got %b want 1", ack_at_done); end
    endtask

    task automatic test_timeout;
        int d0;
        int t0;
        int w;
        logic [7:0] nd;
        logic [9:0] exp_f;
        d0 = done_cnt;
        t0 = tmo_cnt;
        send_byte(8'hFF, 1'b0);
        run_device(4, 1'b0, 1'b0);
        w = 0;
        while (tmo_cnt == t0 && w < TMO + 200) begin
            @(negedge ck);
            w++;
        end
        n_cmp++; if (tmo_cnt - t0 !== 1) begin n_err++; $display("FAIL tmo_pulse_count: got %0d want 1", tmo_cnt - t0); end
        n_cmp++; if (tmo_at - last_fall !== FALL_LAT + TMO) begin n_err++; $display("FAIL tmo_delay: got %0d want %0d", tmo_at - last_fall, FALL_LAT + TMO); end
        n_cmp++; if ({scl_oe, sda_oe} !== 2'b00) begin n_err++; $display("FAIL tmo_oe: got %b want 00", {scl_oe, sda_oe}); end
        repeat (5) @(negedge ck);
        n_cmp++; if (done_cnt !== d0) begin n_err++; $display("FAIL tmo_no_done: got %0d want %0d", done_cnt, d0); end
        nd = 8'($urandom);
        exp_f = model_frame(nd);
        send_byte(nd, 1'b0);
        n_cmp++; if (acc_ready !== 1'b1 || oe_cnt !== INH + REQ) begin n_err++; $display("FAIL tmo_next_accept: got %b/%0d want 1/%0d", acc_ready, oe_cnt, INH + REQ); end
        run_device(11, 1'b0, 1'b0);
        wait_done(d0);
        n_cmp++; if (seen[9:0] !== exp_f) begin n_err++; $display("FAIL tmo_next_frame: got %b want %b", seen[9:0], exp_f); end
    endtask

    task automatic test_glitch;
        int d0;
        logic [9:0] exp_f;
        d0 = done_cnt;
        exp_f = model_frame(8'hAA);
        send_byte(8'hAA, 1'b0);
        run_device(11, 1'b0, 1'b1);
        wait_done(d0);
        n_cmp++; if (seen[9:0] !== exp_f) begin n_err++; $display("FAIL glitch_frame: got %b want %b", seen[9:0], exp_f); end
        n_cmp++; if (done_cnt - d0 !== 1 || ack_at_done !== 1'b0) begin n_err++; $display("FAIL glitch_done: got %0d/%b want 1/0", done_cnt - d0, ack_at_done); end
    endtask

    task automatic test_reset_mid;
        send_byte(8'h55, 1'b0);
        run_device(6, 1'b0, 1'b0);
        n_cmp++; if (sda_oe !== 1'b1) begin n_err++; $display("FAIL mid_bit5_driven: got %b want 1", sda_oe); end
        @(negedge ck);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if ({scl_oe, sda_oe} !== 2'b00) begin n_err++; $display("FAIL mid_async_release: got %b want 00", {scl_oe, sda_oe}); end
        @(negedge ck);
        reset = 1'b1;
        @(negedge ck);
        n_cmp++; if (tif.tx_ready !== 1'b1 || tif.busy !== 1'b0) begin n_err++; $display("FAIL mid_after_release: ready=%b busy=%b want 1/0", tif.tx_ready, tif.busy); end
        repeat (20) @(negedge ck);
    endtask

    task automatic test_random;
        for (int n = 0; n < 4; n++) begin
            int d0;
            logic [7:0] d;
            bit nack;
            logic [9:0] exp_f;
            d = 8'($urandom);
            nack = 1'($urandom_range(0, 1));
            exp_f = model_frame(d);
            d0 = done_cnt;
            send_byte(d, 1'b0);
            run_device(11, nack, 1'b0);
            wait_done(d0);
            n_cmp++; if (seen[9:0] !== exp_f) begin n_err++; $display("FAIL rand_frame[%0d]: data %h got %b want %b", n, d, seen[9:0], exp_f); end
            n_cmp++; if (done_cnt - d0 !== 1 || ack_at_done !== logic'(nack)) begin n_err++; $display("FAIL rand_done[%0d]: got %0d/%b want 1/%b", n, done_cnt - d0, ack_at_done, nack); end
        end
    endtask

    initial begin
        test_reset;
        test_ed;
        test_f4_inhibit;
        test_nack;
        test_timeout;
        test_glitch;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule
